axis_sync_fifo: RTL and testbench



---
 rtl/axis_fifo_pkg.sv | 31 +++
 rtl/fifo_regfile.sv | 29 ++
 rtl/axis_sync_fifo.sv | 112 +++++++++++
 tb/tb_axis_sync_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream FIFO family: pointer width and
// wrap-bit based full/count decoding for binary pointers.
package axis_fifo_pkg;

  // Pointer bus wide enough for any FIFO variant built on these helpers.
  localparam int unsigned MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_bus_t;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Full when index bits match and wrap bits differ.
  function automatic logic fifo_full(input ptr_bus_t wr, input ptr_bus_t rd,
                                     input int unsigned pw);
    ptr_bus_t idx_mask;
    idx_mask = (ptr_bus_t'(1) << (pw - 1)) - ptr_bus_t'(1);
    return ((wr & idx_mask) == (rd & idx_mask)) && (wr[pw-1] != rd[pw-1]);
  endfunction

  // Occupancy: pointer difference modulo 2^pw.
  function automatic ptr_bus_t fifo_count(input ptr_bus_t wr, input ptr_bus_t rd,
                                          input int unsigned pw);
    ptr_bus_t mask;
    mask = (ptr_bus_t'(1) << pw) - ptr_bus_t'(1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x W storage array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_regfile #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: one entry per clock when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read port: combinational so the head entry falls through.
  always_comb begin
    o_rdata = mem_q[i_raddr];
  end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with first-word-fall-through output,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_LVL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_s_tdata,
  input  logic                     i_s_tlast,
  input  logic                     i_s_tvalid,
  output logic                     o_s_tready,
  output logic [DATA_W-1:0]        o_m_tdata,
  output logic                     o_m_tlast,
  output logic                     o_m_tvalid,
  input  logic                     i_m_tready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_almost_full,
  output logic                     o_almost_empty
);

  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  typedef struct packed {
    logic              tlast;
    logic [DATA_W-1:0] tdata;
  } beat_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  beat_t            wr_beat;
  beat_t            rd_beat;

  // Status decode from registered pointers only.
  always_comb begin
    full  = fifo_full(ptr_bus_t'(wr_ptr_q), ptr_bus_t'(rd_ptr_q), PTR_W);
    empty = (wr_ptr_q == rd_ptr_q);
    count = PTR_W'(fifo_count(ptr_bus_t'(wr_ptr_q), ptr_bus_t'(rd_ptr_q), PTR_W));
  end

  // Handshakes: ready is blocked during a flush so the concurrent beat is
  // refused rather than silently dropped.
  always_comb begin
    o_s_tready = !full && !i_flush;
    o_m_tvalid = !empty;
    push       = i_s_tvalid && o_s_tready;
    pop        = o_m_tvalid && i_m_tready && !i_flush;
  end

  // Next-state pointers; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Beat packing for storage and unpacking of the head entry.
  always_comb begin
    wr_beat.tlast = i_s_tlast;
    wr_beat.tdata = i_s_tdata;
    o_m_tdata     = rd_beat.tdata;
    o_m_tlast     = rd_beat.tlast;
  end

  fifo_regfile #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q[ADDR_W-1:0]),
    .i_wdata (wr_beat),
    .i_raddr (rd_ptr_q[ADDR_W-1:0]),
    .o_rdata (rd_beat)
  );

  // Count and threshold flags, same edge as the pointers.
  always_comb begin
    o_count        = count;
    o_almost_full  = (count >= PTR_W'(AFULL_LVL));
    o_almost_empty = (count <= PTR_W'(AEMPTY_LVL));
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo (DATA_W=8, DEPTH=16, levels 14/2).
module tb_axis_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic       m_tvalid;
  logic       m_tready;
  logic [4:0] count;
  logic       afull;
  logic       aempty;

  int unsigned total  = 0;
  int unsigned passed = 0;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_s;

  beat_s q[$];

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        ready;
    int unsigned exp_count;
    logic        exp_tvalid;
    logic [7:0]  exp_tdata;
    logic        exp_tlast;
    logic        exp_aempty;
  } vec_t;

  vec_t vecs[8];

  axis_sync_fifo #(
    .DATA_W     (8),
    .DEPTH      (16),
    .AFULL_LVL  (14),
    .AEMPTY_LVL (2)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_s_tdata      (s_tdata),
    .i_s_tlast      (s_tlast),
    .i_s_tvalid     (s_tvalid),
    .o_s_tready     (s_tready),
    .o_m_tdata      (m_tdata),
    .o_m_tlast      (m_tlast),
    .o_m_tvalid     (m_tvalid),
    .i_m_tready     (m_tready),
    .o_count        (count),
    .o_almost_full  (afull),
    .o_almost_empty (aempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus, checked against the queue model before and after the edge.
  task automatic cycle(input logic fl, input logic v, input logic [7:0] d,
                       input logic l, input logic r);
    bit do_push, do_pop;
    @(negedge clk);
    flush = fl; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    #1;
    do_push = v && !fl && (q.size() < 16);
    do_pop  = r && !fl && (q.size() > 0);
    chk("pre_tready", 32'(s_tready), 32'(!fl && (q.size() < 16)));
    if (do_pop) chk("pop_beat", 32'({m_tlast, m_tdata}), 32'(q[0]));
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(beat_s'({l, d}));
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("tvalid", 32'(m_tvalid), 32'(q.size() > 0));
    chk("tready", 32'(s_tready), 32'(!fl && (q.size() < 16)));
    chk("afull", 32'(afull), 32'(q.size() >= 14));
    chk("aempty", 32'(aempty), 32'(q.size() <= 2));
    if (q.size() > 0) chk("head", 32'({m_tlast, m_tdata}), 32'(q[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned pushed;
    int unsigned cycles;
    rst_n = 1'b0; flush = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tready", 32'(s_tready), 32'd1);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_aempty", 32'(aempty), 32'd1);
    rst_n = 1'b1;

    // valid data last ready | count tvalid tdata tlast aempty
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'hA3, 1'b0, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 8'hA2, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hA4, 1'b1, 1'b1, 2, 1'b1, 8'hA3, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'hA4, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_tvalid = vecs[i].valid; s_tdata = vecs[i].data;
      s_tlast = vecs[i].last; m_tready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
      chk("vec_tvalid", 32'(m_tvalid), 32'(vecs[i].exp_tvalid));
      chk("vec_aempty", 32'(aempty), 32'(vecs[i].exp_aempty));
      if (vecs[i].exp_tvalid) begin
        chk("vec_tdata", 32'(m_tdata), 32'(vecs[i].exp_tdata));
        chk("vec_tlast", 32'(m_tlast), 32'(vecs[i].exp_tlast));
      end
    end
    q.delete();

    // Fill to 16 with the consumer stalled; threshold at 14.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h10 + i - 1), 1'b0, 1'b0);
      chk("fill_afull", 32'(afull), 32'(i >= 14));
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_tready", 32'(s_tready), 32'd0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("overflow_count", 32'(count), 32'd16);
    cycle(1'b0, 1'b1, 8'hEF, 1'b0, 1'b1);
    chk("full_pop_count", 32'(count), 32'd15);
    chk("full_pop_head", 32'(m_tdata), 32'h11);

    // Random traffic starting near full.
    pushed = 0;
    cycles = 0;
    while (pushed < 100 && cycles < 3000) begin
      logic v, r;
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      if (v && q.size() < 16) pushed++;
      cycle(1'b0, v, 8'($urandom), 1'($urandom_range(0, 1)), r);
      cycles++;
    end
    chk("random_done", 32'(pushed >= 100), 32'd1);

    // 40-beat stream with both sides ready; tlast on the final beat.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h40 + i), (i == 40), 1'b1);
      chk("stream_count_le1", 32'(count <= 5'd1), 32'd1);
    end
    chk("stream_last_data", 32'(m_tdata), 32'h68);
    chk("stream_last_tlast", 32'(m_tlast), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush at count 7 with concurrent push and pop.
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd7);
    cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_tvalid", 32'(m_tvalid), 32'd0);
    chk("flush_aempty", 32'(aempty), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-stream at count 5.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 8'hEE; m_tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_tready", 32'(s_tready), 32'd1);
    chk("arst_afull", 32'(afull), 32'd0);
    chk("arst_aempty", 32'(aempty), 32'd1);
    q.delete();
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0);
    chk("post_rst_head", 32'(m_tdata), 32'hC1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_second", 32'({m_tlast, m_tdata}), 32'h1C2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
